ps2_kbd_rx: RTL and testbench

//  PS/2 keyboard receiver feeding the CPU bus PS2 window (20000000-2fffffff).

---
 rtl/ps2_kbd_rx.sv | 178 +++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises, deframes and parity-checks scan codes into a FIFO.
// Optional PS2_BREAK_FILTER_EN drops F0 and the break code that follows it.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       ps2_rd,
  output logic [7:0] key,
  output logic       ps2_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [2:0]    clk_sync_q, clk_sync_d;
  logic [2:0]    dat_sync_q, dat_sync_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          frame_err_q, frame_err_d;
  logic          overflow_q, overflow_d;
  logic          rd_prev_q, rd_prev_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic fall, din, good, err, push, pop_req, pop, full, wr;

`ifdef PS2_BREAK_FILTER_EN
  logic skip_q, skip_d;
`endif

  assign fall = (clk_sync_q[2:1] == 2'b10);
  assign din  = dat_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    good       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall && !din) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_d   = din;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          if (din && (^{shift_q, par_q})) good = 1'b1;
          else err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A stalled device abandons the partial frame
    if (state_q == IDLE || fall) begin
      to_d = '0;
    end else if (to_q == TW'(TIMEOUT - 1)) begin
      to_d    = '0;
      state_d = IDLE;
      err     = 1'b1;
    end else begin
      to_d = to_q + TW'(1);
    end
    frame_err_d = err;
  end

`ifdef PS2_BREAK_FILTER_EN
  always_comb begin
    skip_d = skip_q;
    push   = 1'b0;
    if (err) begin
      skip_d = 1'b0;
    end else if (good) begin
      if (shift_q == 8'hF0) skip_d = 1'b1;
      else if (skip_q)      skip_d = 1'b0;
      else                  push   = 1'b1;
    end
  end
`else
  assign push = good;
`endif

  always_comb begin
    rd_prev_d  = ps2_rd;
    pop_req    = ps2_rd & ~rd_prev_q;
    full       = (count_q == CW'(FIFO_DEPTH));
    pop        = pop_req && (count_q != '0);
    wr         = push && (!full || pop);
    wr_ptr_d   = wr  ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr && !pop)      count_d = count_q + CW'(1);
    else if (pop && !wr) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (push && full && !pop) overflow_d = 1'b1;
    else if (pop_req)         overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clk_sync_q  <= 3'b111;
      dat_sync_q  <= 3'b111;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_q        <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      rd_prev_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef PS2_BREAK_FILTER_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_q        <= to_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      rd_prev_q   <= rd_prev_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
`ifdef PS2_BREAK_FILTER_EN
      skip_q      <= skip_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= shift_q;
  end

  assign key       = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign ps2_ready = (count_q != '0);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: framing, parity, FIFO, read edges, timeout, reset.
// Short TIMEOUT keeps the abort scenario quick.
module tb_ps2_kbd_rx;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ps2_rd = 1'b0;
  logic [7:0] key;
  logic       ps2_ready, overflow, frame_err;

  int vec = 0;
  int bad = 0;
  int errs = 0;

  ps2_kbd_rx #(.FIFO_DEPTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ps2_rd(ps2_rd), .key(key), .ps2_ready(ps2_ready),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err === 1'b1) errs++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame bits LSB first: start, 8 data, parity, stop
  task automatic send(input logic [7:0] b, input logic flip_par,
                      input logic stop_bit, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clk(5);
      ps2_clk = 1'b0;
      wait_clk(10);
      ps2_clk = 1'b1;
      wait_clk(5);
    end
    ps2_data = 1'b1;
  endtask

  task automatic rd_edge();
    @(negedge clk) ps2_rd = 1'b1;
    @(negedge clk) ps2_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) if (ps2_ready) rd_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(3);
    vec++;
    if ({key, ps2_ready, overflow, frame_err} !== 11'h0) begin
      bad++;
      $display("FAIL reset: key=%h rdy=%b ovf=%b ferr=%b want 0", key, ps2_ready, overflow, frame_err);
    end
    rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_good_frame();
    int e0;
    e0 = errs;
    send(8'h1C, 1'b0, 1'b0, 10);
    ps2_data = 1'b1;
    wait_clk(5);
    ps2_clk = 1'b0;
    wait_clk(1);
    repeat (6) begin
      @(negedge clk);
      if (ps2_ready) break;
    end
    vec++;
    if (ps2_ready !== 1'b1 || key !== 8'h1C) begin
      bad++;
      $display("FAIL good_frame: rdy=%b key=%h want 1/1c", ps2_ready, key);
    end
    wait_clk(9);
    ps2_clk = 1'b1;
    wait_clk(5);
    vec++;
    if (errs !== e0) begin
      bad++;
      $display("FAIL good_frame_err: pulses=%0d want 0", errs - e0);
    end
    rd_edge();
    vec++;
    if (ps2_ready !== 1'b0 || key !== 8'h00) begin
      bad++;
      $display("FAIL pop_to_empty: rdy=%b key=%h want 0/00", ps2_ready, key);
    end
  endtask

  task automatic test_bad_parity();
    int e0;
    e0 = errs;
    send(8'h1C, 1'b1, 1'b1, 11);
    wait_clk(5);
    vec++;
    if (errs - e0 !== 1 || ps2_ready !== 1'b0) begin
      bad++;
      $display("FAIL bad_parity: pulses=%0d rdy=%b want 1/0", errs - e0, ps2_ready);
    end
    e0 = errs;
    send(8'h33, 1'b0, 1'b0, 11);
    wait_clk(5);
    vec++;
    if (errs - e0 !== 1 || ps2_ready !== 1'b0) begin
      bad++;
      $display("FAIL bad_stop: pulses=%0d rdy=%b want 1/0", errs - e0, ps2_ready);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b1, 11);
    wait_clk(5);
    vec++;
    if (overflow !== 1'b1 || key !== 8'h01) begin
      bad++;
      $display("FAIL overflow: ovf=%b key=%h want 1/01", overflow, key);
    end
    for (int i = 1; i <= 8; i++) begin
      vec++;
      if (key !== 8'(i) || ps2_ready !== 1'b1) begin
        bad++;
        $display("FAIL fifo_order[%0d]: key=%h rdy=%b want %h/1", i, key, ps2_ready, 8'(i));
      end
      rd_edge();
      if (i == 1) begin
        vec++;
        if (overflow !== 1'b0) begin
          bad++;
          $display("FAIL overflow_clear: ovf=%b want 0", overflow);
        end
      end
    end
    vec++;
    if (ps2_ready !== 1'b0 || key !== 8'h00) begin
      bad++;
      $display("FAIL fifo_empty: rdy=%b key=%h want 0/00", ps2_ready, key);
    end
  endtask

  task automatic test_held_read();
    send(8'h11, 1'b0, 1'b1, 11);
    send(8'h22, 1'b0, 1'b1, 11);
    @(negedge clk) ps2_rd = 1'b1;
    wait_clk(20);
    vec++;
    if (key !== 8'h22 || ps2_ready !== 1'b1) begin
      bad++;
      $display("FAIL held_read: key=%h rdy=%b want 22/1", key, ps2_ready);
    end
    ps2_rd = 1'b0;
    wait_clk(2);
    rd_edge();
    vec++;
    if (ps2_ready !== 1'b0) begin
      bad++;
      $display("FAIL held_read_drain: rdy=%b want 0", ps2_ready);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = errs;
    send(8'h55, 1'b0, 1'b1, 4);
    wait_clk(TO + 50);
    vec++;
    if (errs - e0 !== 1 || ps2_ready !== 1'b0) begin
      bad++;
      $display("FAIL timeout: pulses=%0d rdy=%b want 1/0", errs - e0, ps2_ready);
    end
    send(8'h29, 1'b0, 1'b1, 11);
    wait_clk(5);
    vec++;
    if (key !== 8'h29 || ps2_ready !== 1'b1 || errs - e0 !== 1) begin
      bad++;
      $display("FAIL after_timeout: key=%h rdy=%b pulses=%0d want 29/1/1",
               key, ps2_ready, errs - e0);
    end
    drain();
  endtask

  task automatic test_break();
    logic [7:0] exp [$];
`ifdef PS2_BREAK_FILTER_EN
    exp = '{8'h1D};
`else
    exp = '{8'hF0, 8'h1C, 8'h1D};
`endif
    send(8'hF0, 1'b0, 1'b1, 11);
    send(8'h1C, 1'b0, 1'b1, 11);
    send(8'h1D, 1'b0, 1'b1, 11);
    wait_clk(5);
    foreach (exp[i]) begin
      vec++;
      if (key !== exp[i] || ps2_ready !== 1'b1) begin
        bad++;
        $display("FAIL break[%0d]: key=%h rdy=%b want %h/1", i, key, ps2_ready, exp[i]);
      end
      rd_edge();
    end
    vec++;
    if (ps2_ready !== 1'b0) begin
      bad++;
      $display("FAIL break_empty: rdy=%b want 0", ps2_ready);
    end
  endtask

  task automatic test_rst_mid_frame();
    send(8'h44, 1'b0, 1'b1, 11);
    send(8'h66, 1'b0, 1'b1, 5);
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({key, ps2_ready, overflow, frame_err} !== 11'h0) begin
      bad++;
      $display("FAIL rst_mid: key=%h rdy=%b ovf=%b ferr=%b want 0", key, ps2_ready, overflow, frame_err);
    end
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(3);
    send(8'h3A, 1'b0, 1'b1, 11);
    wait_clk(5);
    vec++;
    if (key !== 8'h3A || ps2_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_rst: key=%h rdy=%b want 3a/1", key, ps2_ready);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_overflow();
    test_held_read();
    test_timeout();
    test_break();
    test_rst_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
